bk_multiword_add_seq: RTL and testbench

Sequencer that runs multi-precision add and subtract on the team's existing 16-bit Brent-Kung adder. It processes one 16-bit limb per cycle, least-significant limb first, and chains the carry through a register. The adder stays outside this block and connects through the add_* ports, so one adder instance can serve wide operands. Operands come in and results go out over valid/ready handshakes.

---
 rtl/bk_multiword_add_seq_if.sv | 28 ++
 rtl/bk_multiword_add_seq.sv | 122 ++++++++++++
 tb/tb_bk_multiword_add_seq.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bk_multiword_add_seq_if.sv
// rtl/bk_multiword_add_seq_if.sv - operand request / result handshake bundle for the multiword add sequencer
interface bk_multiword_add_seq_if #(
    parameter int WORDS = 4
);
    localparam int W = 16 * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/bk_multiword_add_seq.sv
// rtl/bk_multiword_add_seq.sv - limb-serial multi-precision add/subtract driving an external 16-bit adder
module bk_multiword_add_seq #(
    parameter int WORDS = 4,
    parameter int IDX_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    bk_multiword_add_seq_if.slave bus,
    output logic                  busy,
    output logic [15:0]           add_a,
    output logic [15:0]           add_b,
    output logic                  add_cin,
    input  logic [15:0]           add_sum,
    input  logic                  add_cout
);
    localparam int W = 16 * WORDS;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic             sub_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-17:0]    res_q;
    logic [W-1:0]     sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             valid_q;
    logic             accept;
    logic             last;
    logic             done_hs;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        accept       = 1'b0;
        last         = 1'b0;
        done_hs      = 1'b0;
        add_a        = 16'h0;
        add_b        = 16'h0;
        add_cin      = 1'b0;
        bus.in_ready = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                add_a   = a_q[16*idx +: 16];
                add_b   = b_q[16*idx +: 16];
                add_cin = carry;
                if (idx == LAST) begin
                    last     = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    done_hs  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Subtraction is A + ~B + ~borrow, so B is inverted once at accept and
    // the borrow is folded into the initial carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            carry   <= 1'b0;
            valid_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (accept) begin
                a_q   <= bus.in_a;
                b_q   <= bus.in_sub ? ~bus.in_b : bus.in_b;
                sub_q <= bus.in_sub;
                carry <= bus.in_cin ^ bus.in_sub;
                idx   <= '0;
            end
            if (state == RUN) begin
                carry <= add_cout;
                idx   <= idx + 1'b1;
                if (!last) begin
                    res_q[16*idx +: 16] <= add_sum;
                end
            end
            if (last) begin
                sum_q   <= {add_sum, res_q};
                cout_q  <= add_cout ^ sub_q;
                ovf_q   <= (a_q[W-1] == b_q[W-1]) & (add_sum[15] != a_q[W-1]);
                valid_q <= 1'b1;
            end
            if (done_hs) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_bk_multiword_add_seq.sv
// tb/tb_bk_multiword_add_seq.sv - randomized self-checking bench for bk_multiword_add_seq
module tb_bk_multiword_add_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [15:0] add_a, add_b, add_sum;
    logic        add_cin, add_cout;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;

    bk_multiword_add_seq_if #(.WORDS(4)) ifc ();

    bk_multiword_add_seq #(.WORDS(4), .IDX_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (ifc),
        .busy     (busy),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // Stand-in for the external 16-bit adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'h0, add_cin};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void ref_model(input logic [63:0] a, input logic [63:0] b,
                                      input logic s, input logic c,
                                      output logic [63:0] r, output logic co, output logic ov);
        logic [64:0] t;
        if (!s) begin
            t  = {1'b0, a} + {1'b0, b} + {64'h0, c};
            ov = (a[63] == b[63]) && (t[63] != a[63]);
        end else begin
            t  = {1'b0, a} - {1'b0, b} - {64'h0, c};
            ov = (a[63] != b[63]) && (t[63] != a[63]);
        end
        r  = t[63:0];
        co = t[64];
    endfunction

    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic s, input logic c,
                         output logic [63:0] r, output logic co, output logic ov,
                         output int lat, output logic [3:0] cseq, output int acc_cyc);
        int guard;
        guard = 0;
        while (!ifc.in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        ifc.in_a = a; ifc.in_b = b; ifc.in_sub = s; ifc.in_cin = c;
        ifc.in_valid  = 1'b1;
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        ifc.in_valid = 1'b0;
        lat  = 0;
        cseq = 4'h0;
        while (!ifc.out_valid && lat < 20) begin
            if (lat < 4) cseq[lat[1:0]] = add_cin;
            @(posedge clk); #1;
            lat++;
        end
        r  = ifc.out_sum;
        co = ifc.out_cout;
        ov = ifc.out_ovf;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({ifc.out_valid, ifc.in_ready, busy, ifc.out_cout, ifc.out_ovf} !== 5'b01000) begin
            fails++;
            $display("FAIL reset_flags got=%b exp=01000", {ifc.out_valid, ifc.in_ready, busy, ifc.out_cout, ifc.out_ovf});
        end
        tests++;
        if (ifc.out_sum !== 64'h0 || {add_a, add_b, add_cin} !== 33'h0) begin
            fails++;
            $display("FAIL reset_data sum=%h add=%h/%h/%b exp=0", ifc.out_sum, add_a, add_b, add_cin);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add_carry();
        logic [63:0] r; logic co, ov; int lat, acc; logic [3:0] cs;
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, r, co, ov, lat, cs, acc);
        tests++;
        if ({r, co, ov} !== {64'h0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL add_carry got=%h/%b/%b exp=0/1/0", r, co, ov);
        end
        tests++;
        if (cs !== 4'b1110) begin
            fails++;
            $display("FAIL add_cin_seq got=%b exp=1110 (limb0 in lsb)", cs);
        end
        tests++;
        if (lat !== 4) begin
            fails++;
            $display("FAIL latency got=%0d edges after accept exp=4", lat);
        end
    endtask

    task automatic test_sub();
        logic [63:0] r; logic co, ov; int lat, acc; logic [3:0] cs;
        do_op(64'h0, 64'h1, 1'b1, 1'b0, r, co, ov, lat, cs, acc);
        tests++;
        if ({r, co, ov} !== {64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL sub_borrow got=%h/%b/%b exp=ffffffffffffffff/1/0", r, co, ov);
        end
        do_op(64'h5, 64'h3, 1'b1, 1'b1, r, co, ov, lat, cs, acc);
        tests++;
        if ({r, co} !== {64'h1, 1'b0}) begin
            fails++;
            $display("FAIL sub_borrow_in got=%h/%b exp=1/0", r, co);
        end
    endtask

    task automatic test_overflow();
        logic [63:0] r; logic co, ov; int lat, acc; logic [3:0] cs;
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, r, co, ov, lat, cs, acc);
        tests++;
        if ({r, co, ov} !== {64'h8000_0000_0000_0000, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL add_ovf got=%h/%b/%b exp=8000000000000000/0/1", r, co, ov);
        end
        do_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, r, co, ov, lat, cs, acc);
        tests++;
        if ({r, co, ov} !== {64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL sub_ovf got=%h/%b/%b exp=7fffffffffffffff/0/1", r, co, ov);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] a, b, er, held; logic eco, eov; int guard;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        ref_model(a, b, 1'b0, 1'b1, er, eco, eov);
        ifc.out_ready = 1'b0;
        ifc.in_a = a; ifc.in_b = b; ifc.in_sub = 1'b0; ifc.in_cin = 1'b1;
        ifc.in_valid = 1'b1;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        guard = 0;
        while (!ifc.out_valid && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        held = ifc.out_sum;
        tests++;
        if ({held, ifc.out_cout, ifc.out_ovf} !== {er, eco, eov}) begin
            fails++;
            $display("FAIL bp_result got=%h/%b/%b exp=%h/%b/%b", held, ifc.out_cout, ifc.out_ovf, er, eco, eov);
        end
        ifc.in_a = ~a; ifc.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests++;
            if ({ifc.out_valid, ifc.in_ready} !== 2'b10 || ifc.out_sum !== er) begin
                fails++;
                $display("FAIL bp_hold[%0d] valid/ready=%b%b sum=%h exp=10 %h", i, ifc.out_valid, ifc.in_ready, ifc.out_sum, er);
            end
        end
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({ifc.in_ready, ifc.out_valid, busy} !== 3'b100 || ifc.out_sum !== er) begin
            fails++;
            $display("FAIL bp_release ready/valid/busy=%b sum=%h exp=100 %h", {ifc.in_ready, ifc.out_valid, busy}, ifc.out_sum, er);
        end
        ifc.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [63:0] r; logic co, ov; int lat, acc; logic [3:0] cs;
        ifc.out_ready = 1'b1;
        ifc.in_a = 64'hFFFF_0000_FFFF_0000; ifc.in_b = 64'h1234; ifc.in_sub = 1'b0; ifc.in_cin = 1'b0;
        ifc.in_valid = 1'b1;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if ({busy, ifc.out_valid, ifc.in_ready} !== 3'b001 || {add_a, add_b, add_cin} !== 33'h0) begin
            fails++;
            $display("FAIL mid_reset busy/valid/ready=%b add=%h/%h/%b exp=001 0", {busy, ifc.out_valid, ifc.in_ready}, add_a, add_b, add_cin);
        end
        repeat (6) begin
            @(posedge clk); #1;
            tests++;
            if (ifc.out_valid !== 1'b0) begin
                fails++;
                $display("FAIL mid_reset_no_valid got=%b exp=0", ifc.out_valid);
            end
        end
        do_op(64'h1234, 64'h1, 1'b0, 1'b0, r, co, ov, lat, cs, acc);
        tests++;
        if ({r, co, ov} !== {64'h1235, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL after_reset got=%h/%b/%b exp=1235/0/0", r, co, ov);
        end
    endtask

    task automatic test_random();
        logic [63:0] a, b, r, er; logic s, c, co, ov, eco, eov;
        int lat, acc, prev; logic [3:0] cs;
        prev = -1;
        for (int i = 0; i < 1000; i++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) a = {$urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h0, 32'hFFFF_FFFF};
            s = $urandom_range(0, 1); c = $urandom_range(0, 1);
            ref_model(a, b, s, c, er, eco, eov);
            do_op(a, b, s, c, r, co, ov, lat, cs, acc);
            tests++;
            if ({r, co, ov} !== {er, eco, eov}) begin
                fails++;
                $display("FAIL rand[%0d] a=%h b=%h sub=%b cin=%b got=%h/%b/%b exp=%h/%b/%b", i, a, b, s, c, r, co, ov, er, eco, eov);
            end
            if (prev >= 0) begin
                tests++;
                if (acc - prev !== 6) begin
                    fails++;
                    $display("FAIL rand_spacing[%0d] got=%0d exp=6", i, acc - prev);
                end
            end
            prev = acc;
        end
    endtask

    initial begin
        ifc.in_valid = 1'b0; ifc.in_a = '0; ifc.in_b = '0;
        ifc.in_sub = 1'b0; ifc.in_cin = 1'b0; ifc.out_ready = 1'b0;
        test_reset();
        test_add_carry();
        test_sub();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
